slot_btn_ctrl: RTL and testbench
================================

Name: slot_btn_ctrl

Overview:
Front-end button conditioner that produces the start/stop strobes consumed by slot_top.
- Takes the raw, bouncing, asynchronous active-low START and STOP push-buttons.
- Synchronizes and debounces each one, then detects presses.
- Enforces a legal start→stop ordering with a small state machine.
- Emits clean one-cycle active-low strobes plus a spin-status flag.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized input must differ from its stable value before the stable value updates (≥2)
MIN_SPIN_CYCLES, 8, cycles after a start strobe during which stop presses are dropped (≥1)
AUTO_STOP_CYCLES, 256, cycles in SPIN before an automatic stop (used only with SLOT_AUTO_STOP_EN)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
start_n_raw  in  1  raw START button, active-low, asynchronous
stop_n_raw  in  1  raw STOP button, active-low, asynchronous
start_out  out  1  active-low one-cycle start strobe to slot_top.start
stop_out  out  1  active-low one-cycle stop strobe to slot_top.stop
spinning  out  1  high while state ≠ IDLE

Behaviour:
Reset values (async on reset=1):
- start_out=1, stop_out=1, spinning=0, state=IDLE.
- Sync flops = 1, stable values = 1 (released), all counters = 0.

Input conditioning:
- Each input passes through a 2-flop synchronizer (output s).
- Debounce counter: increments each cycle s ≠ stable; clears on any cycle s == stable.
- When the counter reaches DEBOUNCE_CYCLES-1 with s still ≠ stable, stable <= s and the counter clears.
- Press event = stable 1→0 transition. Registered, valid one cycle. Release events are ignored.
- Latency: raw falling edge held steady → strobe low on clock edge DEBOUNCE_CYCLES+3 after the first edge that samples it (7 edges at default).

FSM (IDLE, MIN, SPIN):
- IDLE: start press → start_out=0 for exactly one cycle, load min counter, go to MIN. Stop press in IDLE is dropped.
- MIN: counts MIN_SPIN_CYCLES. Stop and start presses are dropped, not queued. At terminal count → SPIN.
- SPIN: stop press → stop_out=0 for one cycle, go to IDLE. Start presses are dropped.
- Strobes are registered outputs, asserted in the cycle the FSM leaves the state.
- start_out and stop_out are never low in the same cycle.

Boundary conditions:
- Simultaneous start and stop press in IDLE: start wins, stop dropped.
- Stop press in the last MIN cycle: dropped.
- Button held continuously: one press only. A new press requires a debounced release first.
- Reset mid-operation: everything returns to reset values immediately; no strobe is emitted.
  - A button still held after reset deasserts debounces as a fresh press (stable reset = released).
- Counters saturate/clear; no wrap-around is observable.

Optional Feature:
SLOT_AUTO_STOP_EN
- Defined: SPIN runs an idle counter. After AUTO_STOP_CYCLES cycles without a stop press, the block issues stop_out=0 for one cycle and goes to IDLE, exactly like a real press. A real press on the terminal cycle produces a single strobe.
- Undefined: SPIN waits indefinitely. The counter logic is absent.
- Ports are identical in both builds.

Decomposition:
- Package slot_pkg:
  - FSM state encoding (IDLE/MIN/SPIN)
  - counter-width helper function (clog2-based)
  - strobe active level constant STROBE_ACTIVE=1'b0
- Sub-module slot_debounce (synchronizer + debounce counter + press detect), instantiated once per button, parameterized by DEBOUNCE_CYCLES.

Test Plan:
1. Hold reset 10 cycles → start_out=1, stop_out=1, spinning=0. Assert reset mid-cycle → outputs reset without waiting for clk.
2. start_n_raw=0 for 20 cycles, defaults → exactly one start_out=0 cycle on edge 7 after first sample, spinning=1, no further strobes while held.
3. Bounce start_n_raw: 3 cycles low / 1 high, repeated 5× → no strobe. Then 4+ steady low → one strobe.
4. After a start, stop press within the 8-cycle MIN window → no stop_out. Stop press after the window → one stop_out=0 cycle, spinning=0 next cycle.
5. Start and stop pressed on the same edge in IDLE → start_out strobe only, state MIN. Start re-press during SPIN → ignored.
6. With SLOT_AUTO_STOP_EN, AUTO_STOP_CYCLES=16: start, then no stop → stop_out=0 exactly 16 cycles after entering SPIN. Reset asserted mid-SPIN → spinning=0 at once, no stop strobe.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared definitions for the slot button conditioner: FSM states, strobe level
// and the counter-width helper.
`timescale 1ns/1ps

package slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIN  = 2'd1,
    ST_SPIN = 2'd2
  } slot_state_e;

  localparam logic STROBE_ACTIVE = 1'b0;

  // Bits needed for a counter holding 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slot_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and registered
// press (stable 1->0) detector. Releases produce no event.
`timescale 1ns/1ps

module slot_debounce
  import slot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The stable value only moves after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = stable_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/slot_btn_ctrl.sv
// START/STOP button front end: debounces both buttons and sequences them
// through IDLE -> MIN -> SPIN. Build option SLOT_AUTO_STOP_EN adds a SPIN timeout.
`timescale 1ns/1ps

module slot_btn_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned MIN_SPIN_CYCLES  = 8,
  parameter int unsigned AUTO_STOP_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic start_n_raw,
  input  logic stop_n_raw,
  output logic start_out,
  output logic stop_out,
  output logic spinning
);

  localparam int unsigned           MIN_W    = cnt_width(MIN_SPIN_CYCLES);
  localparam logic [MIN_W-1:0]      MIN_LAST = MIN_W'(MIN_SPIN_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || MIN_SPIN_CYCLES < 1 || AUTO_STOP_CYCLES < 1) begin : g_bad_params
      $error("slot_btn_ctrl: illegal parameter value");
    end
  endgenerate

  logic start_press;
  logic stop_press;

  slot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_db (
    .clk    (clk),
    .reset  (reset),
    .btn_n_i(start_n_raw),
    .press_o(start_press)
  );

  slot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_stop_db (
    .clk    (clk),
    .reset  (reset),
    .btn_n_i(stop_n_raw),
    .press_o(stop_press)
  );

  slot_state_e      state_q;
  slot_state_e      state_d;
  logic [MIN_W-1:0] min_cnt_q;
  logic [MIN_W-1:0] min_cnt_d;
  logic             start_q;
  logic             start_d;
  logic             stop_q;
  logic             stop_d;

`ifdef SLOT_AUTO_STOP_EN
  localparam int unsigned           AUTO_W    = cnt_width(AUTO_STOP_CYCLES);
  localparam logic [AUTO_W-1:0]     AUTO_LAST = AUTO_W'(AUTO_STOP_CYCLES - 1);

  logic [AUTO_W-1:0] auto_cnt_q;
  logic [AUTO_W-1:0] auto_cnt_d;
`endif

  // Presses arriving in a state that cannot use them are dropped, never queued.
  always_comb begin
    state_d   = state_q;
    min_cnt_d = min_cnt_q;
    start_d   = ~STROBE_ACTIVE;
    stop_d    = ~STROBE_ACTIVE;
`ifdef SLOT_AUTO_STOP_EN
    auto_cnt_d = auto_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          start_d   = STROBE_ACTIVE;
          min_cnt_d = MIN_LAST;
          state_d   = ST_MIN;
        end
      end
      ST_MIN: begin
        if (min_cnt_q == '0) begin
          state_d = ST_SPIN;
`ifdef SLOT_AUTO_STOP_EN
          auto_cnt_d = AUTO_LAST;
`endif
        end else begin
          min_cnt_d = min_cnt_q - 1'b1;
        end
      end
      ST_SPIN: begin
`ifdef SLOT_AUTO_STOP_EN
        // A real press on the timeout cycle merges into the same single strobe.
        if (stop_press || auto_cnt_q == '0) begin
          stop_d  = STROBE_ACTIVE;
          state_d = ST_IDLE;
        end else begin
          auto_cnt_d = auto_cnt_q - 1'b1;
        end
`else
        if (stop_press) begin
          stop_d  = STROBE_ACTIVE;
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      min_cnt_q <= '0;
      start_q   <= ~STROBE_ACTIVE;
      stop_q    <= ~STROBE_ACTIVE;
    end else begin
      state_q   <= state_d;
      min_cnt_q <= min_cnt_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
    end
  end

`ifdef SLOT_AUTO_STOP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`endif

  assign start_out = start_q;
  assign stop_out  = stop_q;
  assign spinning  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_slot_btn_ctrl.sv
// Directed bench for slot_btn_ctrl: debounce latency, bounce rejection,
// MIN-window drops, start/stop priority, async reset and (optional) auto stop.
`timescale 1ns/1ps

module tb_slot_btn_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start_n_raw;
  logic stop_n_raw;
  logic start_out;
  logic stop_out;
  logic spinning;

  int checks   = 0;
  int failures = 0;

  int cyc           = 0;
  int start_cnt     = 0;
  int stop_cnt      = 0;
  int both_low_cnt  = 0;
  int last_start_cyc = 0;
  int last_stop_cyc  = 0;

  int c0;
  int s0;
  int p0;

  slot_btn_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .MIN_SPIN_CYCLES (8),
    .AUTO_STOP_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_n_raw(start_n_raw),
    .stop_n_raw (stop_n_raw),
    .start_out  (start_out),
    .stop_out   (stop_out),
    .spinning   (spinning)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe bookkeeping: one line per strobe seen, sampled mid-cycle.
  always @(negedge clk) begin
    if (start_out === 1'b0) begin
      start_cnt++;
      last_start_cyc = cyc;
      $display("[%0t] start strobe at edge %0d", $time, cyc);
    end
    if (stop_out === 1'b0) begin
      stop_cnt++;
      last_stop_cyc = cyc;
      $display("[%0t] stop strobe at edge %0d", $time, cyc);
    end
    if (start_out === 1'b0 && stop_out === 1'b0) both_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    start_n_raw = 1'b1;
    stop_n_raw  = 1'b1;
    cycles(10);
    check("rst_start_out", start_out, 1);
    check("rst_stop_out", stop_out, 1);
    check("rst_spinning", spinning, 0);
    reset = 1'b0;
    cycles(3);

    // Held start: single strobe on edge 7 after the first sampling edge.
    s0 = start_cnt; c0 = cyc;
    start_n_raw = 1'b0;
    cycles(20);
    check("hold_start_count", start_cnt - s0, 1);
    check("hold_start_edge", last_start_cyc - c0, 7);
    check("hold_spinning", spinning, 1);
    start_n_raw = 1'b1;
    cycles(8);

    // Stop well after the MIN window, held: one strobe only.
    p0 = stop_cnt; c0 = cyc;
    stop_n_raw = 1'b0;
    cycles(8);
    check("stop_count", stop_cnt - p0, 1);
    check("stop_edge", last_stop_cyc - c0, 7);
    check("stop_idle", spinning, 0);
    cycles(12);
    check("stop_held_once", stop_cnt - p0, 1);
    stop_n_raw = 1'b1;
    cycles(8);

    // Bounce: 3 low / 1 high never survives a 4-cycle debounce.
    s0 = start_cnt;
    repeat (5) begin
      start_n_raw = 1'b0;
      cycles(3);
      start_n_raw = 1'b1;
      cycles(1);
    end
    cycles(8);
    check("bounce_no_strobe", start_cnt - s0, 0);
    check("bounce_idle", spinning, 0);

    // Steady press, then a stop press landing on the last MIN cycle.
    s0 = start_cnt; p0 = stop_cnt; c0 = cyc;
    start_n_raw = 1'b0;
    cycles(8);
    stop_n_raw = 1'b0;
    check("steady_start_count", start_cnt - s0, 1);
    check("steady_start_edge", last_start_cyc - c0, 7);
    cycles(12);
    check("last_min_stop_dropped", stop_cnt - p0, 0);
    check("last_min_spinning", spinning, 1);
    start_n_raw = 1'b1;
    stop_n_raw  = 1'b1;
    cycles(8);

    // Start re-press during SPIN is ignored.
    s0 = start_cnt;
    start_n_raw = 1'b0;
    cycles(10);
    check("spin_start_ignored", start_cnt - s0, 0);
    check("spin_still_spinning", spinning, 1);
    start_n_raw = 1'b1;
    cycles(8);

    p0 = stop_cnt; c0 = cyc;
    stop_n_raw = 1'b0;
    cycles(10);
    check("spin_stop_count", stop_cnt - p0, 1);
    check("spin_stop_edge", last_stop_cyc - c0, 7);
    check("spin_stop_idle", spinning, 0);
    stop_n_raw = 1'b1;
    cycles(8);

    // Simultaneous start and stop in IDLE: start wins.
    s0 = start_cnt; p0 = stop_cnt;
    start_n_raw = 1'b0;
    stop_n_raw  = 1'b0;
    cycles(10);
    check("simul_start_count", start_cnt - s0, 1);
    check("simul_stop_dropped", stop_cnt - p0, 0);
    check("simul_spinning", spinning, 1);
    start_n_raw = 1'b1;
    stop_n_raw  = 1'b1;
    cycles(8);

    // Async reset mid-SPIN, with start held through it.
    p0 = stop_cnt;
    start_n_raw = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_spinning", spinning, 0);
    check("async_rst_start_out", start_out, 1);
    check("async_rst_stop_out", stop_out, 1);
    cycles(3);
    check("async_rst_no_stop", stop_cnt - p0, 0);

    s0 = start_cnt; p0 = stop_cnt; c0 = cyc;
    reset = 1'b0;
    cycles(10);
    check("post_rst_press_count", start_cnt - s0, 1);
    check("post_rst_press_edge", last_start_cyc - c0, 7);
    start_n_raw = 1'b1;

`ifdef SLOT_AUTO_STOP_EN
    // SPIN entered on edge 15; timeout strobe 16 cycles later.
    cycles(23);
    check("auto_stop_count", stop_cnt - p0, 1);
    check("auto_stop_edge", last_stop_cyc - c0, 31);
    check("auto_stop_idle", spinning, 0);
`else
    cycles(40);
    check("no_auto_stop", stop_cnt - p0, 0);
    check("no_auto_spinning", spinning, 1);
    c0 = cyc;
    stop_n_raw = 1'b0;
    cycles(10);
    check("final_stop_count", stop_cnt - p0, 1);
    check("final_stop_edge", last_stop_cyc - c0, 7);
    stop_n_raw = 1'b1;
`endif

    check("never_both_low", both_low_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
